// File: rtl/ccff_loader.sv
// ----------------------------------------------------------------------------
// ccff_loader
//
// Drives the fabric's configuration flip-flop chain. Configuration bytes
// arrive over a valid/ready handshake and are shifted MSB-first onto
// ccff_head, one bit per prog_clk period. The chain's previous contents are
// read back from ccff_tail, one sample per bit, and packed into bytes.
//
// Handshake: a byte transfers on the rising clk edge where data_valid and
// data_ready are both high. data_ready does not depend on data_valid.
// data_valid/data are expected to hold until the transfer happens.
//
// Parameters
//   CHAIN_LEN  total configuration bits in the chain (>= 1)
//   CLK_DIV    clk cycles per prog_clk half-period (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       single-cycle load request (honoured in IDLE or DONE only)
//   data        configuration byte, bit 7 shifted first
//   data_valid  data is valid
//   data_ready  holding register empty, load running, byte quota not met
//   prog_clk    chain shift clock (registered)
//   ccff_head   serial bit into the chain (registered)
//   ccff_tail   serial bit out of the chain
//   tail_byte   last 8 sampled tail bits, first sample in bit 7
//   tail_valid  one-cycle pulse when tail_byte updates
//   busy        load in progress
//   done        load complete, until the next accepted start
//   dbg_state   current FSM state encoding
// ----------------------------------------------------------------------------
module ccff_loader #(
   parameter int CHAIN_LEN = 512,
   parameter int CLK_DIV   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       prog_clk,
   output logic       ccff_head,
   input  logic       ccff_tail,
   output logic [7:0] tail_byte,
   output logic       tail_valid,
   output logic       busy,
   output logic       done,
   output logic [2:0] dbg_state
);

   localparam int BW     = $clog2(CHAIN_LEN + 1);
   localparam int NBYTES = (CHAIN_LEN + 7) / 8;
   localparam int YW     = $clog2(NBYTES + 1);
   localparam int HW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_LEN - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
   localparam logic [YW-1:0] BYTES_MAX = YW'(NBYTES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOW   = 3'd2,
      S_HIGH  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next_state;

   logic [7:0]      r_hold;
   logic            r_hold_full;
   logic [YW-1:0]   r_bytes;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_in_byte;
   logic [BW-1:0]   r_bit_cnt;
   logic [HW-1:0]   r_half_cnt;
   logic [7:0]      r_tail_sr;
   logic [2:0]      r_tail_cnt;
   logic [7:0]      r_tail_byte;
   logic            r_tail_valid;
   logic            r_prog_clk;
   logic            r_head;

   logic            w_start_ok;
   logic            w_fetch_go;
   logic            w_low_end;
   logic            w_high_end;
   logic            w_last_bit;
   logic            w_half_end;
   logic            w_active;
   logic            w_data_ready;
   logic            w_accept;
   logic [7:0]      w_tail_shifted;
   logic [7:0]      w_tail_align;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_start_ok   = 1'b0;
      w_fetch_go   = 1'b0;
      w_low_end    = 1'b0;
      w_high_end   = 1'b0;
      w_last_bit   = 1'b0;
      w_half_end   = (r_half_cnt == HALF_LAST);
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_start_ok   = 1'b1;
               w_next_state = S_FETCH;
            end
         end
         S_FETCH: begin
            // An empty holding register is an underrun: just wait.
            if (r_hold_full) begin
               w_fetch_go   = 1'b1;
               w_next_state = S_LOW;
            end
         end
         S_LOW: begin
            if (w_half_end) begin
               w_low_end    = 1'b1;
               w_next_state = S_HIGH;
            end
         end
         S_HIGH: begin
            if (w_half_end) begin
               w_high_end = 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_last_bit   = 1'b1;
                  w_next_state = S_DONE;
               end else if (r_bit_in_byte == 3'd7) begin
                  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_LOW;
               end
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_active     = (r_state == S_FETCH) || (r_state == S_LOW) || (r_state == S_HIGH);
   // The byte quota keeps the trailing bits of a partial final byte from
   // pulling in an extra byte that would never be shifted.
   assign w_data_ready = w_active && !r_hold_full && (r_bytes < BYTES_MAX);
   assign w_accept     = data_valid && w_data_ready;

   // Residual tail bits are moved up to the MSBs; unsampled LSBs become 0.
   assign w_tail_shifted = r_tail_sr << (4'd8 - {1'b0, r_tail_cnt});
   assign w_tail_align   = w_tail_shifted;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold        <= 8'h00;
         r_hold_full   <= 1'b0;
         r_bytes       <= '0;
         r_shift       <= 8'h00;
         r_bit_in_byte <= 3'd0;
         r_bit_cnt     <= '0;
         r_half_cnt    <= '0;
         r_tail_sr     <= 8'h00;
         r_tail_cnt    <= 3'd0;
         r_tail_byte   <= 8'h00;
         r_tail_valid  <= 1'b0;
         r_prog_clk    <= 1'b0;
         r_head        <= 1'b0;
      end else begin
         r_tail_valid <= 1'b0;
         r_prog_clk   <= (w_next_state == S_HIGH);

         if (w_start_ok) begin
            r_bit_cnt   <= '0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_bytes     <= '0;
            r_tail_cnt  <= 3'd0;
            r_tail_sr   <= 8'h00;
         end else begin
            // Accept and fetch never coincide: ready needs an empty register,
            // fetch needs a full one.
            if (w_accept) begin
               r_hold      <= data;
               r_hold_full <= 1'b1;
               r_bytes     <= r_bytes + YW'(1);
            end

            if (w_fetch_go) begin
               r_shift       <= r_hold;
               r_head        <= r_hold[7];
               r_hold_full   <= 1'b0;
               r_bit_in_byte <= 3'd0;
               r_half_cnt    <= '0;
            end

            if ((r_state == S_LOW) || (r_state == S_HIGH)) begin
               r_half_cnt <= w_half_end ? '0 : r_half_cnt + HW'(1);
            end

            // Sample the tail just before prog_clk rises, while the chain
            // output still shows the bit about to be shifted out.
            if (w_low_end) begin
               r_tail_sr  <= {r_tail_sr[6:0], ccff_tail};
               r_tail_cnt <= r_tail_cnt + 3'd1;
               if (r_tail_cnt == 3'd7) begin
                  r_tail_byte  <= {r_tail_sr[6:0], ccff_tail};
                  r_tail_valid <= 1'b1;
               end
            end

            if (w_high_end) begin
               r_bit_cnt <= r_bit_cnt + BW'(1);
               if (!w_last_bit && (r_bit_in_byte != 3'd7)) begin
                  r_shift       <= {r_shift[6:0], 1'b0};
                  r_head        <= r_shift[6];
                  r_bit_in_byte <= r_bit_in_byte + 3'd1;
               end
               if (w_last_bit && (r_tail_cnt != 3'd0)) begin
                  r_tail_byte  <= w_tail_align;
                  r_tail_valid <= 1'b1;
               end
            end
         end
      end
   end

   assign data_ready = w_data_ready;
   assign prog_clk   = r_prog_clk;
   assign ccff_head  = r_head;
   assign tail_byte  = r_tail_byte;
   assign tail_valid = r_tail_valid;
   assign busy       = w_active;
   assign done       = (r_state == S_DONE);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_ccff_loader.sv
// ----------------------------------------------------------------------------
// tb_ccff_loader
//
// Two loaders share one clock: a 16-bit chain and a 12-bit chain (partial
// final byte), each with CLK_DIV=2 and a behavioural shift-register chain
// hanging off prog_clk/ccff_head/ccff_tail. Loads on the 16-bit instance
// come from a table of {bytes, gap, options, expected stream, expected tail
// bytes}; reset-mid-load, underrun and mid-load start are options on rows.
// ----------------------------------------------------------------------------
module tb_ccff_loader;

   // ------------------------------------------------------------ clock
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ------------------------------------------------------------ 16-bit DUT
   logic       rst16 = 1'b0, start16 = 1'b0, valid16 = 1'b0;
   logic [7:0] data16 = 8'h00;
   logic       ready16, pclk16, head16, tail16, tv16, busy16, done16;
   logic [7:0] tb16;
   logic [2:0] st16;

   ccff_loader #(.CHAIN_LEN(16), .CLK_DIV(2)) dut16 (
      .clk(clk), .rst_n(rst16), .start(start16), .data(data16),
      .data_valid(valid16), .data_ready(ready16), .prog_clk(pclk16),
      .ccff_head(head16), .ccff_tail(tail16), .tail_byte(tb16),
      .tail_valid(tv16), .busy(busy16), .done(done16), .dbg_state(st16)
   );

   logic [15:0] chain16 = 16'hBEEF;
   assign tail16 = chain16[15];
   always @(posedge pclk16) chain16 <= {chain16[14:0], head16};

   int          edges16 = 0;
   logic [15:0] bits16  = 16'h0000;
   always @(posedge pclk16) begin
      edges16 <= edges16 + 1;
      bits16  <= {bits16[14:0], head16};
   end

   int acc16 = 0;
   always @(posedge clk) if (valid16 && ready16) acc16 <= acc16 + 1;

   int         hp_run16 = 0, hp_err16 = 0, tn16 = 0;
   logic       hhead16 = 1'b0;
   logic [7:0] tlog16 [0:31];
   always @(negedge clk) begin
      if (!rst16) hp_run16 <= 0;
      else if (pclk16) begin
         hp_run16 <= hp_run16 + 1;
         if (hp_run16 == 0) hhead16 <= head16;
         else if (head16 !== hhead16) hp_err16 <= hp_err16 + 1;
      end else begin
         if (hp_run16 != 0 && hp_run16 != 2) hp_err16 <= hp_err16 + 1;
         hp_run16 <= 0;
      end
      if (tv16) begin
         tlog16[tn16[4:0]] <= tb16;
         tn16 <= tn16 + 1;
      end
   end

   // ------------------------------------------------------------ 12-bit DUT
   logic       rst12 = 1'b0, start12 = 1'b0, valid12 = 1'b0;
   logic [7:0] data12 = 8'h00;
   logic       ready12, pclk12, head12, tail12, tv12, busy12, done12;
   logic [7:0] tb12;
   logic [2:0] st12;

   ccff_loader #(.CHAIN_LEN(12), .CLK_DIV(2)) dut12 (
      .clk(clk), .rst_n(rst12), .start(start12), .data(data12),
      .data_valid(valid12), .data_ready(ready12), .prog_clk(pclk12),
      .ccff_head(head12), .ccff_tail(tail12), .tail_byte(tb12),
      .tail_valid(tv12), .busy(busy12), .done(done12), .dbg_state(st12)
   );

   logic [11:0] chain12 = 12'hABC;
   assign tail12 = chain12[11];
   always @(posedge pclk12) chain12 <= {chain12[10:0], head12};

   int          edges12 = 0;
   logic [11:0] bits12  = 12'h000;
   always @(posedge pclk12) begin
      edges12 <= edges12 + 1;
      bits12  <= {bits12[10:0], head12};
   end

   int acc12 = 0;
   always @(posedge clk) if (valid12 && ready12) acc12 <= acc12 + 1;

   int         hp_run12 = 0, hp_err12 = 0, tn12 = 0;
   logic [7:0] tlast12 = 8'h00;
   always @(negedge clk) begin
      if (!rst12) hp_run12 <= 0;
      else if (pclk12) hp_run12 <= hp_run12 + 1;
      else begin
         if (hp_run12 != 0 && hp_run12 != 2) hp_err12 <= hp_err12 + 1;
         hp_run12 <= 0;
      end
      if (tv12) begin
         tlast12 <= tb12;
         tn12    <= tn12 + 1;
      end
   end

   // ------------------------------------------------------------ drivers
   task automatic pulse_start16();
      @(negedge clk); start16 = 1'b1;
      @(negedge clk); start16 = 1'b0;
   endtask

   task automatic send16(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk); data16 = b; valid16 = 1'b1;
      while (!ready16 && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) check("send16_timeout", 32'(n), 32'd0);
      @(posedge clk); #1 valid16 = 1'b0;
   endtask

   task automatic wait_edges16(input int target, input bit need_low);
      int n;
      n = 0;
      @(negedge clk);
      while (!(edges16 >= target && (!need_low || !pclk16)) && n < 5000) begin
         @(negedge clk); n++;
      end
      if (n >= 5000) check("edges16_timeout", 32'(edges16), 32'(target));
   endtask

   task automatic wait_done16(output logic prev_pc, output logic busy_at);
      int n;
      n = 0;
      prev_pc = 1'b0;
      @(negedge clk);
      while (!done16 && n < 5000) begin prev_pc = pclk16; @(negedge clk); n++; end
      if (n >= 5000) check("done16_timeout", 32'(n), 32'd0);
      busy_at = busy16;
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      int          gap;
      bit          mid_start;
      bit          rst5;
      logic [15:0] exp_stream;
      logic [7:0]  exp_t0;
      logic [7:0]  exp_t1;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int base_e, base_t, base_acc, base_hp, stall_err, t1i;
      logic prev_pc, busy_at;
      int n;

      vecs[0] = '{8'hA5, 8'h3C, 0,  1'b0, 1'b0, 16'hA53C, 8'hBE, 8'hEF};
      vecs[1] = '{8'hA5, 8'h3C, 50, 1'b0, 1'b0, 16'hA53C, 8'hA5, 8'h3C};
      vecs[2] = '{8'h12, 8'h34, 0,  1'b1, 1'b0, 16'h1234, 8'hA5, 8'h3C};
      vecs[3] = '{8'hA5, 8'h3C, 0,  1'b0, 1'b1, 16'hA53C, 8'h46, 8'h94};
      vecs[4] = '{8'hC3, 8'h0F, 7,  1'b0, 1'b0, 16'hC30F, 8'hA5, 8'h3C};

      // Reset values while reset is held.
      #12;
      check("rst_prog_clk",   32'(pclk16),  32'd0);
      check("rst_ccff_head",  32'(head16),  32'd0);
      check("rst_data_ready", 32'(ready16), 32'd0);
      check("rst_busy",       32'(busy16),  32'd0);
      check("rst_done",       32'(done16),  32'd0);
      check("rst_tail_byte",  32'(tb16),    32'h00);
      check("rst_tail_valid", 32'(tv16),    32'd0);
      @(negedge clk); #2 rst16 = 1'b1; rst12 = 1'b1;

      // Table-driven loads on the 16-bit chain.
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].rst5) begin
            base_e = edges16;
            pulse_start16();
            send16(8'hA5);
            wait_edges16(base_e + 5, 1'b0);
            // prog_clk is high here; reset must pull it low at once.
            #2 rst16 = 1'b0;
            #1;
            check("arst_prog_clk",   32'(pclk16),  32'd0);
            check("arst_busy",       32'(busy16),  32'd0);
            check("arst_data_ready", 32'(ready16), 32'd0);
            check("arst_done",       32'(done16),  32'd0);
            @(negedge clk); #2 rst16 = 1'b1;
         end

         base_e   = edges16;
         base_t   = tn16;
         base_acc = acc16;
         base_hp  = hp_err16;
         pulse_start16();
         send16(vecs[i].b0);
         if (vecs[i].gap > 0) begin
            // Hold the second byte back until the FSM sits in FETCH.
            wait_edges16(base_e + 8, 1'b1);
            stall_err = 0;
            for (int c = 0; c < vecs[i].gap; c++) begin
               @(negedge clk);
               if (pclk16 || edges16 != base_e + 8 || st16 != 3'd1) stall_err++;
            end
            check($sformatf("v%0d_underrun_stall", i), 32'(stall_err), 32'd0);
         end
         send16(vecs[i].b1);
         if (vecs[i].mid_start) begin
            wait_edges16(base_e + 10, 1'b0);
            pulse_start16();
         end
         wait_done16(prev_pc, busy_at);

         check($sformatf("v%0d_stream", i),    32'(bits16),            32'(vecs[i].exp_stream));
         check($sformatf("v%0d_edges", i),     32'(edges16 - base_e),  32'd16);
         check($sformatf("v%0d_bytes", i),     32'(acc16 - base_acc),  32'd2);
         check($sformatf("v%0d_halfper", i),   32'(hp_err16 - base_hp), 32'd0);
         check($sformatf("v%0d_tail_n", i),    32'(tn16 - base_t),     32'd2);
         check($sformatf("v%0d_tail0", i),     32'(tlog16[base_t[4:0]]), 32'(vecs[i].exp_t0));
         t1i = base_t + 1;
         check($sformatf("v%0d_tail1", i),     32'(tlog16[t1i[4:0]]),  32'(vecs[i].exp_t1));
         check($sformatf("v%0d_done_busy", i), 32'(busy_at),           32'd0);
         check($sformatf("v%0d_done_after_high", i), 32'(prev_pc),     32'd1);
         check($sformatf("v%0d_chain", i),     32'(chain16),           32'(vecs[i].exp_stream));
      end

      // 12-bit chain: partial final byte, data_valid kept high past the quota.
      @(negedge clk); start12 = 1'b1;
      @(negedge clk); start12 = 1'b0;
      n = 0;
      data12 = 8'hFF; valid12 = 1'b1;
      while (acc12 < 1 && n < 2000) begin @(negedge clk); n++; end
      data12 = 8'h80;
      while (acc12 < 2 && n < 2000) begin @(negedge clk); n++; end
      data12 = 8'h55;
      prev_pc = 1'b0;
      while (!done12 && n < 5000) begin prev_pc = pclk12; @(negedge clk); n++; end
      if (n >= 5000) check("done12_timeout", 32'(n), 32'd0);
      check("c12_tail_valid_at_done", 32'(tv12),   32'd1);
      check("c12_done_after_high",    32'(prev_pc), 32'd1);
      check("c12_busy_at_done",       32'(busy12),  32'd0);
      repeat (4) @(negedge clk);
      valid12 = 1'b0;
      check("c12_stream",    32'(bits12),   32'hFF8);
      check("c12_edges",     32'(edges12),  32'd12);
      check("c12_bytes",     32'(acc12),    32'd2);
      check("c12_tail_n",    32'(tn12),     32'd2);
      check("c12_tail_last", 32'(tlast12),  32'hC0);
      check("c12_halfper",   32'(hp_err12), 32'd0);
      check("c12_chain",     32'(chain12),  32'hFF8);
      check("c12_state",     32'(st12),     32'd4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
